// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses a framed program download arriving from the UART receive stage.
// It writes each assembled 16-bit word to program memory and holds the CPU in reset while the
// download is in progress.
// Frame layout: SYNC 0xA5, LEN_L, LEN_H, 2*LEN data bytes (little-endian words), CSUM.
// The frame is good when LEN_L + LEN_H + all data bytes + CSUM == 0 (mod 256).
// Optional feature macro: UART_LOADER_TIMEOUT_EN. When it is defined, the loader aborts a frame
// after TIMEOUT_CYCLES sys_clk cycles pass without a received byte.
module uart_prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_ok,
  output logic                  load_err
);

  localparam logic [7:0]            SyncByte = 8'hA5;
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  // Largest legal word count; one bit wider than LEN so that 2**16 still compares correctly.
  localparam logic [16:0]           MaxLen   = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StLenL,
    StLenH,
    StDataLo,
    StDataHi,
    StCsum
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              len_l_q, len_l_d;
  logic [7:0]              lo_q, lo_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [7:0]              sum_q, sum_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    hold_q, hold_d;
  logic                    ok_q, ok_d;
  logic                    err_q, err_d;

  logic [7:0]              sum_add;
  logic [15:0]             len_rx;

  // The running sum includes the incoming byte; carries are discarded.
  assign sum_add = sum_q + rx_data;
  assign len_rx  = {rx_data, len_l_q};

`ifdef UART_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`else
  // Without the timeout feature, TIMEOUT_CYCLES has no effect.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State and output registers; asynchronous reset returns everything to idle values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_l_q <= 8'h00;
      lo_q    <= 8'h00;
      cnt_q   <= 16'h0000;
      sum_q   <= 8'h00;
      addr_q  <= BaseAddr;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      len_l_q <= len_l_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Frame parser: next-state and registered-output logic. It advances only on byte strobes.
  always_comb begin
    state_d = state_q;
    len_l_d = len_l_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    ok_d    = 1'b0;
    err_d   = err_q;
`ifdef UART_LOADER_TIMEOUT_EN
    tmo_d   = tmo_q + 32'd1;
`endif

    // The address steps one cycle after each write strobe.
    // After the last word it therefore points at BASE_ADDR+LEN.
    if (we_q) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end

    if (rx_data_wr) begin
      if (state_q != StIdle) begin
        sum_d = sum_add;
      end
      unique case (state_q)
        StIdle: begin
          // Bytes other than SYNC are ignored here.
          if (rx_data == SyncByte) begin
            state_d = StLenL;
            hold_d  = 1'b1;
            err_d   = 1'b0;
            sum_d   = 8'h00;
            addr_d  = BaseAddr;
          end
        end
        StLenL: begin
          len_l_d = rx_data;
          state_d = StLenH;
        end
        StLenH: begin
          if (len_rx == 16'h0000) begin
            state_d = StCsum;
          end else if ({1'b0, len_rx} > MaxLen) begin
            state_d = StIdle;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StDataLo;
            cnt_d   = len_rx;
          end
        end
        StDataLo: begin
          lo_d    = rx_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          wdata_d = {rx_data, lo_q};
          we_d    = 1'b1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? StCsum : StDataLo;
        end
        StCsum: begin
          state_d = StIdle;
          hold_d  = 1'b0;
          if (sum_add == 8'h00) begin
            ok_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef UART_LOADER_TIMEOUT_EN
    // The counter restarts on every byte and stays cleared while idle.
    // Expiry abandons the frame.
    if (rx_data_wr || (state_q == StIdle)) begin
      tmo_d = 32'd0;
    end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = 32'd0;
      state_d = StIdle;
      err_d   = 1'b1;
      hold_d  = 1'b0;
      ok_d    = 1'b0;
    end
`endif
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign cpu_hold  = hold_q;
  assign load_ok   = ok_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader.
// The reference model builds each frame from a list of words, computes the two's-complement
// checksum arithmetically, and predicts which writes and flags should result.
module tb_uart_prog_loader;

  localparam int unsigned AW   = 10;
  localparam int unsigned BASE = 0;
  localparam int unsigned TMO  = 100;

  logic          sys_clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_data_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic          cpu_hold;
  logic          load_ok;
  logic          load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] fw [0:1023];
  logic [15:0] wq_addr [$];
  logic [15:0] wq_data [$];
  int          ok_cnt;

  uart_prog_loader #(
    .ADDR_WIDTH    (AW),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_data_wr(rx_data_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Record every write and every load_ok pulse away from the active edge.
  always @(negedge sys_clk) begin
    if (mem_we) begin
      wq_addr.push_back(16'(mem_addr));
      wq_data.push_back(mem_wdata);
    end
    if (load_ok) ok_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sys_clk);
    rx_data    = b;
    rx_data_wr = 1'b1;
    @(negedge sys_clk);
    rx_data_wr = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    ok_cnt = 0;
  endtask

  // Send one frame of len words taken from fw[]; corrupt spoils the checksum.
  // Then compare the observed writes and flags against the model.
  task automatic run_frame(input int len, input bit corrupt, input string tag);
    logic [7:0]  s;
    logic [7:0]  c;
    logic [15:0] l16;
    int          nw;
    l16 = 16'(len);
    s   = l16[7:0] + l16[15:8];
    for (int i = 0; i < len; i++) s = s + fw[i][7:0] + fw[i][15:8];
    c = 8'd0 - s;
    if (corrupt) c = c + 8'd1;
    clear_log();
    send_byte(8'hA5, $urandom_range(0, 2));
    send_byte(l16[7:0], $urandom_range(0, 2));
    check({tag, " hold_in_frame"}, 32'(cpu_hold), 32'd1);
    check({tag, " err_cleared"}, 32'(load_err), 32'd0);
    send_byte(l16[15:8], $urandom_range(0, 2));
    for (int i = 0; i < len; i++) begin
      send_byte(fw[i][7:0], $urandom_range(0, 2));
      send_byte(fw[i][15:8], $urandom_range(0, 2));
    end
    send_byte(c, 0);
    repeat (3) @(negedge sys_clk);
    nw = wq_addr.size();
    check({tag, " n_writes"}, 32'(nw), 32'(len));
    for (int i = 0; i < len && i < nw; i++) begin
      check({tag, " waddr"}, 32'(wq_addr[i]), 32'((BASE + i) % (1 << AW)));
      check({tag, " wdata"}, 32'(wq_data[i]), 32'(fw[i]));
    end
    check({tag, " load_ok"}, 32'(ok_cnt), corrupt ? 32'd0 : 32'd1);
    check({tag, " load_err"}, 32'(load_err), corrupt ? 32'd1 : 32'd0);
    check({tag, " hold_rel"}, 32'(cpu_hold), 32'd0);
    check({tag, " end_addr"}, 32'(mem_addr), 32'((BASE + len) % (1 << AW)));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " addr"}, 32'(mem_addr), 32'(BASE));
    check({tag, " wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, " we"}, 32'(mem_we), 32'd0);
    check({tag, " hold"}, 32'(cpu_hold), 32'd0);
    check({tag, " ok"}, 32'(load_ok), 32'd0);
    check({tag, " err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    logic [7:0] jb;
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_data_wr = 1'b0;
    ok_cnt     = 0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Stray bytes while idle are ignored.
    clear_log();
    send_byte(8'h00, 1);
    send_byte(8'h12, 1);
    repeat (2) @(negedge sys_clk);
    check("idle_junk writes", 32'(wq_addr.size()), 32'd0);
    check("idle_junk hold", 32'(cpu_hold), 32'd0);

    // Two-word frame, good and then bad checksum.
    fw[0] = 16'h1234;
    fw[1] = 16'h5678;
    run_frame(2, 1'b0, "two_good");
    run_frame(2, 1'b1, "two_bad");

    // Empty frame, then an oversize length.
    run_frame(0, 1'b0, "len0");
    clear_log();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    repeat (3) @(negedge sys_clk);
    check("oversize err", 32'(load_err), 32'd1);
    check("oversize hold", 32'(cpu_hold), 32'd0);
    check("oversize writes", 32'(wq_addr.size()), 32'd0);
    check("oversize ok", 32'(ok_cnt), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    run_frame(2, 1'b0, "after_reset");

    // Random frames with junk bytes between them. The data may contain 0xA5.
    for (int f = 0; f < 10; f++) begin
      int len;
      bit bad;
      jb = 8'($urandom);
      if (jb == 8'hA5) jb = 8'h5A;
      send_byte(jb, $urandom_range(0, 2));
      len = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++)
        fw[i] = ($urandom_range(0, 4) == 0) ? 16'hA5A5 : 16'($urandom);
      run_frame(len, bad, "rand");
    end

    // Maximum length frame; the end address wraps.
    for (int i = 0; i < 1024; i++) fw[i] = 16'($urandom);
    run_frame(1024, 1'b0, "maxlen");

    // Silence in the middle of a frame.
    clear_log();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
`ifdef UART_LOADER_TIMEOUT_EN
    repeat (TMO + 20) @(negedge sys_clk);
    check("timeout err", 32'(load_err), 32'd1);
    check("timeout hold", 32'(cpu_hold), 32'd0);
    check("timeout ok", 32'(ok_cnt), 32'd0);
`else
    repeat (10000) @(negedge sys_clk);
    check("no_timeout hold", 32'(cpu_hold), 32'd1);
    check("no_timeout err", 32'(load_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
